pending_req_scanner: RTL and testbench

//  Sticky request collector and scanner that feeds the 1024:10 index encoder path.
//  - Accumulates single-cycle request pulses into a pending register.
//  - Presents the highest-numbered pending index on a valid/ready output.
//  - Clears each bit once its index is accepted.

---
 rtl/pending_req_scanner.sv | 167 ++++++++++++++++
 tb/tb_pending_req_scanner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pending_req_scanner.sv
// pending_req_scanner
//   Collects single-cycle request pulses into a sticky pending register and
//   offers the highest-numbered pending index on a valid/ready output. Each
//   index is removed from pending at the edge it is loaded into the output.
//
//   Optional feature macro: SCAN_COALESCE_CNT_EN
//     Adds coalesce_cnt, a saturating count of request pulses that landed on
//     a bit that was already pending.
module pending_req_scanner #(
    parameter int N = 1024,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] set_vec,
    input  logic         clr_all,
    output logic [W-1:0] idx_o,
    output logic         idx_valid,
    input  logic         idx_ready,
`ifdef SCAN_COALESCE_CNT_EN
    output logic [15:0]  coalesce_cnt,
`endif
    output logic         pend_any
);

    // The encoder contract relies on every index value mapping to a real line.
    if (N != (1 << W)) begin : g_bad_params
        $error("pending_req_scanner: N must equal 2**W");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Highest set bit; later (higher) hits overwrite earlier ones. All-zero
    // input yields 0 so idx never carries X.
    function automatic logic [W-1:0] find_highest(input logic [N-1:0] vec);
        logic [W-1:0] r;
        r = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            r = vec[i] ? W'(i) : r;
        end
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [W-1:0]   idx_q, idx_d;
    logic           pend_any_q, pend_any_d;

    logic [W-1:0]   hi_idx_s;
    logic           any_s;
    logic           load_s;
    logic [N-1:0]   clr_mask_s;

    assign hi_idx_s = find_highest(pending_q);
    assign any_s    = |pending_q;

    // Next-state and load decision; a flush cancels any load at the same edge
    // because the candidate it would load is being discarded.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_s && !clr_all) begin
                    load_s  = 1'b1;
                    idx_d   = hi_idx_s;
                    state_d = ST_OFFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (idx_ready) begin
                    if (any_s && !clr_all) begin
                        load_s  = 1'b1;
                        idx_d   = hi_idx_s;
                        state_d = ST_OFFER;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_OFFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending update: clear the loaded bit, then OR in new requests so a
    // request hitting the loaded bit keeps it pending.
    always_comb begin
        clr_mask_s = {N{1'b0}};
        if (load_s) begin
            clr_mask_s = {{(N-1){1'b0}}, 1'b1} << hi_idx_s;
        end else begin
            clr_mask_s = {N{1'b0}};
        end
        if (clr_all) begin
            pending_d = {N{1'b0}};
        end else begin
            pending_d = (pending_q & ~clr_mask_s) | set_vec;
        end
        pend_any_d = |pending_d;
    end

    // State, pending register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= {N{1'b0}};
            idx_q      <= {W{1'b0}};
            pend_any_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            pend_any_q <= pend_any_d;
        end
    end

    assign idx_o     = idx_q;
    assign idx_valid = (state_q == ST_OFFER);
    assign pend_any  = pend_any_q;

`ifdef SCAN_COALESCE_CNT_EN
    // Number of set bits in vec; W+1 bits holds the all-ones count.
    function automatic logic [W:0] popcount(input logic [N-1:0] vec);
        logic [W:0] c;
        c = {(W+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            c = c + {{W{1'b0}}, vec[i]};
        end
        return c;
    endfunction

    logic [15:0] coal_cnt_q, coal_cnt_d;
    logic [16:0] coal_sum_s;

    // Saturating accumulation of requests that merged into a pending bit.
    always_comb begin
        coal_sum_s = {1'b0, coal_cnt_q} + 17'(popcount(set_vec & pending_q));
        if (coal_sum_s[16]) begin
            coal_cnt_d = 16'hFFFF;
        end else begin
            coal_cnt_d = coal_sum_s[15:0];
        end
    end

    // Counter register; survives clr_all, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            coal_cnt_q <= 16'h0000;
        end else begin
            coal_cnt_q <= coal_cnt_d;
        end
    end

    assign coalesce_cnt = coal_cnt_q;
`endif

endmodule

// File: tb/tb_pending_req_scanner.sv
// Self-checking bench for pending_req_scanner. Expected indices are pushed to
// a scoreboard when requests are driven and popped on each observed handshake.
module tb_pending_req_scanner;

    localparam int N = 1024;
    localparam int W = 10;

    logic         clk;
    logic         rst;
    logic [N-1:0] set_vec;
    logic         clr_all;
    logic [W-1:0] idx_o;
    logic         idx_valid;
    logic         idx_ready;
    logic         pend_any;
`ifdef SCAN_COALESCE_CNT_EN
    logic [15:0]  coalesce_cnt;
`endif

    int total;
    int bad;
    int exp_q[$];

    pending_req_scanner #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_vec   (set_vec),
        .clr_all   (clr_all),
        .idx_o     (idx_o),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
`ifdef SCAN_COALESCE_CNT_EN
        .coalesce_cnt (coalesce_cnt),
`endif
        .pend_any  (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle; inputs driven after this apply at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_vec = '1; clr_all = 1'b0; idx_ready = 1'b1;
        tick(); tick();
        rst = 1'b0; set_vec = '0;
        total++; if (idx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", idx_valid); end
        total++; if (pend_any !== 1'b0) begin bad++; $display("FAIL reset_pend_any got=%0b exp=0", pend_any); end
        total++; if (idx_o !== 10'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx_o); end
        tick();
        total++; if (idx_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%0b exp=0", idx_valid); end
    endtask

    task automatic test_order();
        int cyc;
        int e;
        set_vec = '0; set_vec[3] = 1'b1; set_vec[700] = 1'b1; set_vec[1023] = 1'b1;
        idx_ready = 1'b1;
        exp_q.push_back(1023); exp_q.push_back(700); exp_q.push_back(3);
        tick();
        set_vec = '0;
        total++; if (idx_valid !== 1'b0) begin bad++; $display("FAIL order_lat1_valid got=%0b exp=0", idx_valid); end
        total++; if (pend_any !== 1'b1) begin bad++; $display("FAIL order_lat1_pend got=%0b exp=1", pend_any); end
        tick();
        total++; if (idx_valid !== 1'b1) begin bad++; $display("FAIL order_lat2_valid got=%0b exp=1", idx_valid); end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            if (idx_valid === 1'b1) begin
                e = exp_q.pop_front();
                total++; if (idx_o !== W'(e)) begin bad++; $display("FAIL order_idx got=%0d exp=%0d", idx_o, e); end
            end
            tick();
            cyc++;
        end
        total++; if (cyc !== 3) begin bad++; $display("FAIL order_b2b_cycles got=%0d exp=3", cyc); end
        total++; if (idx_valid !== 1'b0) begin bad++; $display("FAIL order_end_valid got=%0b exp=0", idx_valid); end
        total++; if (pend_any !== 1'b0) begin bad++; $display("FAIL order_end_pend got=%0b exp=0", pend_any); end
        exp_q.delete();
    endtask

    task automatic test_hold();
        int cyc;
        int e;
        set_vec = '0; set_vec[5] = 1'b1; set_vec[9] = 1'b1;
        idx_ready = 1'b0;
        exp_q.push_back(9); exp_q.push_back(5);
        tick();
        set_vec = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            total++; if (idx_valid !== 1'b1 || idx_o !== 10'd9) begin bad++; $display("FAIL hold_idx cyc=%0d got=%0d/%0b exp=9/1", i, idx_o, idx_valid); end
            tick();
        end
        idx_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            if (idx_valid === 1'b1) begin
                e = exp_q.pop_front();
                total++; if (idx_o !== W'(e)) begin bad++; $display("FAIL hold_drain got=%0d exp=%0d", idx_o, e); end
            end
            tick();
            cyc++;
        end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL hold_timeout got=%0d left exp=0", exp_q.size()); end
        total++; if (idx_valid !== 1'b0) begin bad++; $display("FAIL hold_end_valid got=%0b exp=0", idx_valid); end
        exp_q.delete();
    endtask

    task automatic test_set_wins();
        int cyc;
        int e;
        set_vec = '0; set_vec[9] = 1'b1;
        idx_ready = 1'b0;
        exp_q.push_back(9);
        tick();
        // Same edge that loads 9: set 9 again, it must stay pending.
        exp_q.push_back(9);
        tick();
        set_vec = '0;
        total++; if (idx_valid !== 1'b1 || idx_o !== 10'd9) begin bad++; $display("FAIL setwin_load got=%0d/%0b exp=9/1", idx_o, idx_valid); end
        total++; if (pend_any !== 1'b1) begin bad++; $display("FAIL setwin_pend got=%0b exp=1", pend_any); end
        idx_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            if (idx_valid === 1'b1) begin
                e = exp_q.pop_front();
                total++; if (idx_o !== W'(e)) begin bad++; $display("FAIL setwin_idx got=%0d exp=%0d", idx_o, e); end
            end
            tick();
            cyc++;
        end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL setwin_timeout got=%0d left exp=0", exp_q.size()); end
        total++; if (idx_valid !== 1'b0 || pend_any !== 1'b0) begin bad++; $display("FAIL setwin_end got=%0b/%0b exp=0/0", idx_valid, pend_any); end
        exp_q.delete();
    endtask

    task automatic test_clr_all();
        int cyc;
        int e;
        set_vec = '0; set_vec[1] = 1'b1; set_vec[2] = 1'b1; set_vec[6] = 1'b1;
        idx_ready = 1'b0;
        exp_q.push_back(6);
        tick();
        set_vec = '0;
        tick();
        total++; if (pend_any !== 1'b1) begin bad++; $display("FAIL clr_pre_pend got=%0b exp=1", pend_any); end
        clr_all = 1'b1; set_vec[4] = 1'b1;
        tick();
        clr_all = 1'b0; set_vec = '0;
        total++; if (pend_any !== 1'b0) begin bad++; $display("FAIL clr_pend got=%0b exp=0", pend_any); end
        total++; if (idx_valid !== 1'b1 || idx_o !== 10'd6) begin bad++; $display("FAIL clr_offer_kept got=%0d/%0b exp=6/1", idx_o, idx_valid); end
        idx_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            if (idx_valid === 1'b1) begin
                e = exp_q.pop_front();
                total++; if (idx_o !== W'(e)) begin bad++; $display("FAIL clr_idx got=%0d exp=%0d", idx_o, e); end
            end
            tick();
            cyc++;
        end
        tick();
        total++; if (idx_valid !== 1'b0) begin bad++; $display("FAIL clr_end_valid got=%0b exp=0", idx_valid); end
        total++; if (pend_any !== 1'b0) begin bad++; $display("FAIL clr_end_pend got=%0b exp=0", pend_any); end
        exp_q.delete();
    endtask

`ifdef SCAN_COALESCE_CNT_EN
    task automatic test_coalesce();
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (coalesce_cnt !== 16'd0) begin bad++; $display("FAIL coal_reset got=%0d exp=0", coalesce_cnt); end
        idx_ready = 1'b0;
        set_vec = '0; set_vec[20] = 1'b1;
        tick();
        set_vec = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_vec = '0; set_vec[7] = 1'b1;
            tick();
        end
        set_vec = '0;
        total++; if (coalesce_cnt !== 16'd2) begin bad++; $display("FAIL coal_cnt got=%0d exp=2", coalesce_cnt); end
        total++; if (idx_valid !== 1'b1 || idx_o !== 10'd20) begin bad++; $display("FAIL coal_offer got=%0d/%0b exp=20/1", idx_o, idx_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (idx_valid !== 1'b0 || coalesce_cnt !== 16'd0) begin bad++; $display("FAIL coal_rst got=%0b/%0d exp=0/0", idx_valid, coalesce_cnt); end
        total++; if (pend_any !== 1'b0 || idx_o !== 10'd0) begin bad++; $display("FAIL coal_rst_state got=%0b/%0d exp=0/0", pend_any, idx_o); end
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; set_vec = '0; clr_all = 1'b0; idx_ready = 1'b0;
        #1;
        test_reset();
        test_order();
        test_hold();
        test_set_wins();
        test_clr_all();
`ifdef SCAN_COALESCE_CNT_EN
        test_coalesce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
